// File: rtl/tx_bram_loader.sv
// tx_bram_loader: writer side of the TX packet buffer.
// Takes the host word stream and stores it in the BRAM write port from
// address 0 upward. It then hands the packet to dot11_tx with a
// phy_tx_start / phy_tx_started / phy_tx_done handshake.
// Optional packet statistics are enabled with the TX_LOADER_STATS_EN macro.
module tx_bram_loader #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_WORDS     = 1024,
  parameter int START_TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_waddr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  phy_tx_start,
  input  logic                  phy_tx_started,
  input  logic                  phy_tx_done,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   word_count,
`ifdef TX_LOADER_STATS_EN
  output logic [31:0]           pkt_sent_cnt,
  output logic [15:0]           pkt_drop_cnt,
`endif
  input  logic                  err_clear,
  output logic                  err_overflow,
  output logic                  err_timeout
);

  localparam int WC_W    = ADDR_WIDTH + 1;
  localparam int TIMER_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MAX_WORDS - 1);
  localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    START,
    WAIT_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic                    bram_we_q, bram_we_d;
  logic [ADDR_WIDTH-1:0]   bram_waddr_q, bram_waddr_d;
  logic [DATA_WIDTH-1:0]   bram_wdata_q, bram_wdata_d;
  logic                    start_q, start_d;
  logic [WC_W-1:0]         word_count_q, word_count_d;
  logic                    err_ovf_q, err_ovf_d;
  logic                    err_to_q, err_to_d;
  logic                    set_ovf, set_to;
  logic                    beat;

  // Accept words only in the streaming states and never while reset is held
  assign s_ready = !reset && ((state_q == IDLE) || (state_q == LOAD) || (state_q == DRAIN));
  assign beat    = s_valid && s_ready;

  assign bram_we      = bram_we_q;
  assign bram_waddr   = bram_waddr_q;
  assign bram_wdata   = bram_wdata_q;
  assign phy_tx_start = start_q;
  assign busy         = (state_q != IDLE);
  assign word_count   = word_count_q;
  assign err_overflow = err_ovf_q;
  assign err_timeout  = err_to_q;

  // Next-state logic: write pipeline, handshake sequencing and error detection
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    timer_d      = '0;
    bram_we_d    = 1'b0;
    bram_waddr_d = bram_waddr_q;
    bram_wdata_d = bram_wdata_q;
    word_count_d = word_count_q;
    set_ovf      = 1'b0;
    set_to       = 1'b0;

    case (state_q)
      IDLE: begin
        wr_ptr_d = '0;
        if (beat) begin
          bram_we_d    = 1'b1;
          bram_waddr_d = '0;
          bram_wdata_d = s_data;
          wr_ptr_d     = ADDR_WIDTH'(1);
          if (s_last) begin
            word_count_d = WC_W'(1);
            state_d      = START;
          end else if (LAST_ADDR == '0) begin
            set_ovf = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (beat) begin
          bram_we_d    = 1'b1;
          bram_waddr_d = wr_ptr_q;
          bram_wdata_d = s_data;
          wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(1);
          if (s_last) begin
            word_count_d = {1'b0, wr_ptr_q} + WC_W'(1);
            state_d      = START;
          end else if (wr_ptr_q == LAST_ADDR) begin
            set_ovf = 1'b1;
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        wr_ptr_d = '0;
        if (beat && s_last) begin
          state_d = IDLE;
        end
      end

      START: begin
        wr_ptr_d = '0;
        timer_d  = start_q ? (timer_q + TIMER_W'(1)) : '0;
        if (phy_tx_started && phy_tx_done) begin
          state_d = IDLE;
        end else if (phy_tx_started) begin
          state_d = WAIT_DONE;
        end else if (start_q && (timer_q == TIMER_LAST)) begin
          set_to  = 1'b1;
          state_d = IDLE;
        end
      end

      WAIT_DONE: begin
        wr_ptr_d = '0;
        if (phy_tx_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    start_d   = (state_q == START) && (state_d == START);
    err_ovf_d = set_ovf | (err_ovf_q & ~err_clear);
    err_to_d  = set_to  | (err_to_q  & ~err_clear);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      timer_q      <= '0;
      bram_we_q    <= 1'b0;
      bram_waddr_q <= '0;
      bram_wdata_q <= '0;
      start_q      <= 1'b0;
      word_count_q <= '0;
      err_ovf_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      timer_q      <= timer_d;
      bram_we_q    <= bram_we_d;
      bram_waddr_q <= bram_waddr_d;
      bram_wdata_q <= bram_wdata_d;
      start_q      <= start_d;
      word_count_q <= word_count_d;
      err_ovf_q    <= err_ovf_d;
      err_to_q     <= err_to_d;
    end
  end

`ifdef TX_LOADER_STATS_EN
  logic        sent_pulse;
  logic        drop_pulse;
  logic [31:0] sent_q;
  logic [15:0] drop_q;

  // A packet counts as sent when dot11_tx reports done; timeouts are drops
  assign sent_pulse = ((state_q == WAIT_DONE) && phy_tx_done) ||
                      ((state_q == START) && phy_tx_started && phy_tx_done);
  assign drop_pulse = set_ovf | set_to;

  assign pkt_sent_cnt = sent_q;
  assign pkt_drop_cnt = drop_q;

  // Free-running wrap-around statistics counters, untouched by err_clear
  always_ff @(posedge clock) begin
    if (reset) begin
      sent_q <= '0;
      drop_q <= '0;
    end else begin
      if (sent_pulse) sent_q <= sent_q + 32'd1;
      if (drop_pulse) drop_q <= drop_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_bram_loader.sv
// Directed testbench for tx_bram_loader, built with MAX_WORDS=8 so the
// overflow path is reachable with short packets.
module tb_tx_bram_loader;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int ST = 255;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          bram_we;
  logic [AW-1:0] bram_waddr;
  logic [DW-1:0] bram_wdata;
  logic          phy_tx_start;
  logic          phy_tx_started = 1'b0;
  logic          phy_tx_done = 1'b0;
  logic          busy;
  logic [AW:0]   word_count;
  logic          err_clear = 1'b0;
  logic          err_overflow;
  logic          err_timeout;
`ifdef TX_LOADER_STATS_EN
  logic [31:0]   pkt_sent_cnt;
  logic [15:0]   pkt_drop_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  tx_bram_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(MW), .START_TIMEOUT(ST)
  ) dut (
    .clock(clock), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
    .phy_tx_start(phy_tx_start), .phy_tx_started(phy_tx_started),
    .phy_tx_done(phy_tx_done), .busy(busy), .word_count(word_count),
`ifdef TX_LOADER_STATS_EN
    .pkt_sent_cnt(pkt_sent_cnt), .pkt_drop_cnt(pkt_drop_cnt),
`endif
    .err_clear(err_clear), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_ready); end
    vectors++; if (bram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we: got %b expected 0", bram_we); end
    vectors++; if (bram_waddr !== '0 || bram_wdata !== '0) begin miscompares++; $display("[TB] FAIL reset_addr_data: got %0h/%0h expected 0/0", bram_waddr, bram_wdata); end
    vectors++; if (phy_tx_start !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_start_busy: got %b%b expected 00", phy_tx_start, busy); end
    vectors++; if (word_count !== '0 || err_overflow !== 1'b0 || err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_count_errs: got %0d %b %b expected 0 0 0", word_count, err_overflow, err_timeout); end
    reset = 1'b0;
    #1;
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_s_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_four_word();
    logic [DW-1:0] exp;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 64'h11 * 64'(i + 1);
      s_data = exp;
      s_last = (i == 3);
      tick();
      vectors++; if (bram_we !== 1'b1 || bram_waddr !== AW'(i) || bram_wdata !== exp) begin miscompares++; $display("[TB] FAIL four_write%0d: got we=%b a=%0d d=%0h expected we=1 a=%0d d=%0h", i, bram_we, bram_waddr, bram_wdata, i, exp); end
    end
    s_valid = 1'b0; s_last = 1'b0;
    vectors++; if (phy_tx_start !== 1'b0) begin miscompares++; $display("[TB] FAIL four_start_early: got %b expected 0", phy_tx_start); end
    tick();
    vectors++; if (phy_tx_start !== 1'b1 || bram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL four_start_rise: got start=%b we=%b expected 1 0", phy_tx_start, bram_we); end
    vectors++; if (word_count !== 11'd4) begin miscompares++; $display("[TB] FAIL four_word_count: got %0d expected 4", word_count); end
    vectors++; if (s_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL four_start_state: got ready=%b busy=%b expected 0 1", s_ready, busy); end
    repeat (4) tick();
    vectors++; if (phy_tx_start !== 1'b1) begin miscompares++; $display("[TB] FAIL four_start_hold: got %b expected 1", phy_tx_start); end
    phy_tx_started = 1'b1;
    tick();
    phy_tx_started = 1'b0;
    vectors++; if (phy_tx_start !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL four_started_drop: got start=%b busy=%b expected 0 1", phy_tx_start, busy); end
    tick();
    vectors++; if (phy_tx_start !== 1'b0 || s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL four_wait_done: got start=%b ready=%b expected 0 0", phy_tx_start, s_ready); end
    phy_tx_done = 1'b1;
    tick();
    phy_tx_done = 1'b0;
    vectors++; if (busy !== 1'b0 || s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL four_done_idle: got busy=%b ready=%b expected 0 1", busy, s_ready); end
  endtask

  task automatic test_one_word();
    s_valid = 1'b1; s_last = 1'b1; s_data = 64'hAA;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    vectors++; if (bram_we !== 1'b1 || bram_waddr !== '0 || bram_wdata !== 64'hAA) begin miscompares++; $display("[TB] FAIL one_write: got we=%b a=%0d d=%0h expected 1 0 aa", bram_we, bram_waddr, bram_wdata); end
    vectors++; if (word_count !== 11'd1 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL one_count: got %0d busy=%b expected 1 1", word_count, busy); end
    tick();
    vectors++; if (phy_tx_start !== 1'b1) begin miscompares++; $display("[TB] FAIL one_start: got %b expected 1", phy_tx_start); end
    phy_tx_started = 1'b1; phy_tx_done = 1'b1;
    tick();
    phy_tx_started = 1'b0; phy_tx_done = 1'b0;
    vectors++; if (busy !== 1'b0 || phy_tx_start !== 1'b0 || s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL one_fast_idle: got busy=%b start=%b ready=%b expected 0 0 1", busy, phy_tx_start, s_ready); end
    phy_tx_done = 1'b1;
    tick();
    phy_tx_done = 1'b0;
    vectors++; if (busy !== 1'b0 || phy_tx_start !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_done_ignored: got busy=%b start=%b expected 0 0", busy, phy_tx_start); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp;
    int bad_start;
    bad_start = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp = 64'h100 + 64'(i);
      s_data = exp;
      s_last = (i == 9);
      if (i >= 8) begin
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_drain_ready%0d: got %b expected 1", i, s_ready); end
      end
      tick();
      if (phy_tx_start !== 1'b0) bad_start++;
      if (i < 8) begin
        vectors++; if (bram_we !== 1'b1 || bram_waddr !== AW'(i) || bram_wdata !== exp) begin miscompares++; $display("[TB] FAIL ovf_write%0d: got we=%b a=%0d d=%0h expected 1 %0d %0h", i, bram_we, bram_waddr, bram_wdata, i, exp); end
      end else begin
        vectors++; if (bram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_discard%0d: got we=%b expected 0", i, bram_we); end
      end
      if (i == 7) begin
        vectors++; if (err_overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag: got %b expected 1", err_overflow); end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    repeat (3) begin
      tick();
      if (phy_tx_start !== 1'b0) bad_start++;
    end
    vectors++; if (bad_start !== 0) begin miscompares++; $display("[TB] FAIL ovf_no_start: got %0d start cycles expected 0", bad_start); end
    vectors++; if (busy !== 1'b0 || word_count !== 11'd1) begin miscompares++; $display("[TB] FAIL ovf_idle_count: got busy=%b count=%0d expected 0 1", busy, word_count); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    vectors++; if (err_overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_clear: got %b expected 0", err_overflow); end
  endtask

  task automatic test_timeout();
    int high_cycles;
    high_cycles = 0;
    s_valid = 1'b1; s_data = 64'h5; s_last = 1'b0;
    tick();
    s_data = 64'h6; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    vectors++; if (phy_tx_start !== 1'b0 || word_count !== 11'd2) begin miscompares++; $display("[TB] FAIL to_enter: got start=%b count=%0d expected 0 2", phy_tx_start, word_count); end
    for (int k = 1; k <= ST; k++) begin
      tick();
      if (phy_tx_start === 1'b1) high_cycles++;
    end
    vectors++; if (high_cycles !== ST) begin miscompares++; $display("[TB] FAIL to_high_cycles: got %0d expected %0d", high_cycles, ST); end
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL to_flag_early: got %b expected 0", err_timeout); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    vectors++; if (phy_tx_start !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL to_abort: got start=%b busy=%b expected 0 0", phy_tx_start, busy); end
    vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL to_set_wins: got %b expected 1", err_timeout); end
    tick();
    vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL to_sticky: got %b expected 1", err_timeout); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL to_clear: got %b expected 0", err_timeout); end
  endtask

  task automatic test_reset_mid();
    s_valid = 1'b1; s_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_data = 64'h30 + 64'(i);
      tick();
    end
    s_valid = 1'b0;
    reset = 1'b1;
    #1;
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_load_ready: got %b expected 0", s_ready); end
    tick();
    vectors++; if (bram_we !== 1'b0 || busy !== 1'b0 || word_count !== '0 || bram_waddr !== '0) begin miscompares++; $display("[TB] FAIL rst_load_outputs: got we=%b busy=%b count=%0d a=%0d expected 0 0 0 0", bram_we, busy, word_count, bram_waddr); end
    reset = 1'b0;
    tick();
    vectors++; if (bram_we !== 1'b0 || phy_tx_start !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_after: got we=%b start=%b expected 0 0", bram_we, phy_tx_start); end
    s_valid = 1'b1; s_data = 64'h7;
    tick();
    vectors++; if (bram_we !== 1'b1 || bram_waddr !== '0 || bram_wdata !== 64'h7) begin miscompares++; $display("[TB] FAIL rst_load_restart: got we=%b a=%0d d=%0h expected 1 0 7", bram_we, bram_waddr, bram_wdata); end
    s_data = 64'h8; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    phy_tx_started = 1'b1;
    tick();
    phy_tx_started = 1'b0;
    reset = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0 || phy_tx_start !== 1'b0 || word_count !== '0) begin miscompares++; $display("[TB] FAIL rst_wait_outputs: got busy=%b start=%b count=%0d expected 0 0 0", busy, phy_tx_start, word_count); end
    reset = 1'b0;
    s_valid = 1'b1; s_last = 1'b1; s_data = 64'h9;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    vectors++; if (bram_we !== 1'b1 || bram_waddr !== '0 || bram_wdata !== 64'h9) begin miscompares++; $display("[TB] FAIL rst_wait_restart: got we=%b a=%0d d=%0h expected 1 0 9", bram_we, bram_waddr, bram_wdata); end
    tick();
    phy_tx_started = 1'b1; phy_tx_done = 1'b1;
    tick();
    phy_tx_started = 1'b0; phy_tx_done = 1'b0;
  endtask

  task automatic test_toggle_valid();
    logic [DW-1:0] exp;
    s_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp = 64'h200 + 64'(i / 2);
      s_valid = (i % 2 == 0);
      s_data = exp;
      s_last = (i == 8);
      tick();
      if (i % 2 == 0) begin
        vectors++; if (bram_we !== 1'b1 || bram_waddr !== AW'(i / 2) || bram_wdata !== exp) begin miscompares++; $display("[TB] FAIL tog_write%0d: got we=%b a=%0d d=%0h expected 1 %0d %0h", i, bram_we, bram_waddr, bram_wdata, i / 2, exp); end
      end else begin
        vectors++; if (bram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL tog_gap%0d: got we=%b expected 0", i, bram_we); end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    vectors++; if (word_count !== 11'd5 || phy_tx_start !== 1'b1) begin miscompares++; $display("[TB] FAIL tog_count: got count=%0d start=%b expected 5 1", word_count, phy_tx_start); end
    phy_tx_started = 1'b1;
    tick();
    phy_tx_started = 1'b0;
    phy_tx_done = 1'b1;
    tick();
    phy_tx_done = 1'b0;
    vectors++; if (busy !== 1'b0 || s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL tog_idle: got busy=%b ready=%b expected 0 1", busy, s_ready); end
`ifdef TX_LOADER_STATS_EN
    vectors++; if (pkt_sent_cnt !== 32'd2 || pkt_drop_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL stats: got sent=%0d drop=%0d expected 2 0", pkt_sent_cnt, pkt_drop_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_four_word();
    test_one_word();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_toggle_valid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_bram_loader.md
Name: tx_bram_loader

Overview:
- Writer side of the TX packet buffer: takes a 64-bit packet word stream from the host interface, writes it into the dual-port BRAM from address 0 upward, then hands off to dot11_tx.
- Handoff: raises phy_tx_start, waits for phy_tx_started, then phy_tx_done; only then accepts the next packet.
- Sits between the host/DMA stream and the BRAM write port. dot11_tx reads the other BRAM port through bram_addr/bram_din.

Parameters:
- ADDR_WIDTH, 10, BRAM word address width.
- DATA_WIDTH, 64, stream and BRAM word width.
- MAX_WORDS, 1024, highest usable word count per packet. Must be ≤ 2^ADDR_WIDTH.
- START_TIMEOUT, 255, cycles to wait for phy_tx_started before aborting.

Ports:
- clock  in  1  system clock (200 MHz domain)
- reset  in  1  synchronous, active-high reset
- s_data  in  DATA_WIDTH  packet word
- s_valid  in  1  s_data valid
- s_last  in  1  final word of packet
- s_ready  out  1  loader accepts a word this cycle
- bram_we  out  1  BRAM write enable
- bram_waddr  out  ADDR_WIDTH  BRAM write address
- bram_wdata  out  DATA_WIDTH  BRAM write data
- phy_tx_start  out  1  start request to dot11_tx
- phy_tx_started  in  1  dot11_tx acknowledged start
- phy_tx_done  in  1  dot11_tx finished packet
- busy  out  1  high in any state other than IDLE
- word_count  out  ADDR_WIDTH+1  word count of the last accepted packet
- err_clear  in  1  clears sticky error flags
- err_overflow  out  1  sticky: packet exceeded MAX_WORDS
- err_timeout  out  1  sticky: phy_tx_started never arrived

Behaviour:
- Reset values (all outputs): s_ready=0 while reset is high. bram_we=0, bram_waddr=0, bram_wdata=0, phy_tx_start=0, busy=0, word_count=0, err_overflow=0, err_timeout=0. State=IDLE, wr_ptr=0.
- Reset mid-operation aborts immediately. There is no BRAM write and no phy_tx_start on the cycle after reset.
- s_ready is combinational: 1 in IDLE, LOAD and DRAIN when reset is low; 0 otherwise.
- Beat = s_valid && s_ready.
- Write latency is 1 cycle. A beat at cycle N gives bram_we=1, bram_waddr=wr_ptr, bram_wdata=s_data at cycle N+1. wr_ptr then increments. bram_we is 0 on every non-beat cycle.
- IDLE:
  - wr_ptr=0.
  - Beat writes address 0.
  - With s_last: go to START and set word_count=1.
  - Without s_last: go to LOAD.
- LOAD: each beat writes at wr_ptr.
  - s_last: word_count=wr_ptr+1, go to START.
  - !s_last and wr_ptr==MAX_WORDS-1: word is written, err_overflow set, go to DRAIN.
- DRAIN:
  - Beats are accepted and discarded (no writes).
  - Beat with s_last: go to IDLE. No PHY start.
- START:
  - phy_tx_start=1, registered. It first goes high the cycle after the last BRAM write.
  - Timeout counter starts at 0 and increments each cycle.
  - phy_tx_started=1: drop phy_tx_start next cycle and go to WAIT_DONE.
  - phy_tx_started and phy_tx_done high in the same cycle: go straight to IDLE.
  - Counter reaches START_TIMEOUT without phy_tx_started: drop phy_tx_start, set err_timeout, go to IDLE.
- WAIT_DONE:
  - phy_tx_start=0.
  - phy_tx_done=1: go to IDLE. s_ready is high the following cycle.
- phy_tx_done outside START/WAIT_DONE is ignored.
- Errors:
  - err_clear clears both flags on the next cycle.
  - If a set and err_clear coincide, the set wins.
- word_count holds until the next packet completes loading. It is not updated for overflowed packets.

Optional Feature:
- Macro TX_LOADER_STATS_EN.
- When defined, add outputs:
  - pkt_sent_cnt (32 bits): increments on each WAIT_DONE→IDLE transition and on a START→IDLE transition by simultaneous started+done.
  - pkt_drop_cnt (16 bits): increments on each overflow or timeout abort.
  - Both counters wrap at the maximum value, reset to 0, and are not affected by err_clear.
- When undefined, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- 4-word packet 0x11..0x44 with s_last on word 4:
  - BRAM addr 0..3 hold 0x11..0x44.
  - word_count=4.
  - phy_tx_start rises the cycle after the addr-3 write.
  - started pulse after 5 cycles drops start; done pulse returns to IDLE; s_ready=1 the next cycle.
- 1-word packet (s_last on first beat):
  - Single write to addr 0, word_count=1, START entered.
  - started and done asserted in the same cycle → IDLE directly.
- MAX_WORDS=8, 10-word packet:
  - Addresses 0..7 written, err_overflow=1.
  - Words 9–10 are accepted with bram_we=0.
  - phy_tx_start never asserts.
  - err_clear then clears the flag.
- phy_tx_started held low, START_TIMEOUT=255:
  - phy_tx_start high for exactly 255 cycles (counter values 0..254), then low.
  - err_timeout=1, state IDLE.
  - err_clear in the same cycle as the set leaves err_timeout=1.
- Reset asserted during LOAD after 3 beats and during WAIT_DONE:
  - All outputs return to their reset values.
  - The next packet writes from addr 0.
- s_valid toggling every other cycle during LOAD:
  - Writes are contiguous in address with gaps in bram_we.
  - word_count matches the number of beats.
